// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS edge shaper: FSM states, widths and
// the 16-bit saturation helper.
package prbs_pkg;

  localparam int unsigned DIV_W     = 17;
  localparam int unsigned DIVISOR_W = 8;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned CALC_W    = 18;

  localparam logic signed [CALC_W-1:0] SAT_HI = CALC_W'(32'sd32767);
  localparam logic signed [CALC_W-1:0] SAT_LO = CALC_W'(-32'sd32768);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RAMP = 2'd2
  } state_t;

  // Clamp an 18-bit signed intermediate into the 16-bit DAC code range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [CALC_W-1:0] x);
    if (x > SAT_HI) begin
      return SAMPLE_W'(SAT_HI);
    end else if (x < SAT_LO) begin
      return SAMPLE_W'(SAT_LO);
    end
    return SAMPLE_W'(x);
  endfunction

endpackage

// File: rtl/prbs_step_divider.sv
// Restoring divider, one quotient bit per cycle: start loads the operands and
// done pulses for one cycle DIV_W cycles later with the quotient held stable.
module prbs_step_divider #(
  parameter int unsigned DIV_W = prbs_pkg::DIV_W
) (
  input  logic                               dac_clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DIV_W-1:0]                   dividend,
  input  logic [prbs_pkg::DIVISOR_W-1:0]     divisor,
  output logic                               done,
  output logic [DIV_W-1:0]                   quotient
);
  import prbs_pkg::*;

  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  logic [CNT_W-1:0]     cnt;
  logic [DIVISOR_W-1:0] rem;
  logic [DIVISOR_W:0]   trial_c;
  logic [DIVISOR_W:0]   diff_c;
  logic                 fits_c;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial_c = {rem, quotient[DIV_W-1]};
    diff_c  = trial_c - {1'b0, divisor};
    fits_c  = (trial_c >= {1'b0, divisor});
  end

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt      <= CNT_W'(DIV_W);
        rem      <= '0;
        quotient <= dividend;
      end else if (cnt != '0) begin
        rem      <= fits_c ? DIVISOR_W'(diff_c) : DIVISOR_W'(trial_c);
        quotient <= {quotient[DIV_W-2:0], fits_c};
        cnt      <= cnt - CNT_W'(1);
        done     <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/prbs_edge_shaper.sv
// Turns a PRBS bit stream into DAC samples with programmable amplitude, offset
// and linear edge ramps; level/step recomputation runs whenever config changes.
module prbs_edge_shaper #(
  parameter int unsigned DIV_W = prbs_pkg::DIV_W
) (
  input  logic        dac_clk,
  input  logic        reset,
  input  logic        prbs_bit_in,
  input  logic        prbs_data_valid,
  input  logic [7:0]  edge_time_config,
  input  logic [15:0] amplitude_config,
  input  logic [15:0] dc_offset_config,
  output logic [15:0] dac_data_out,
  output logic        dac_data_valid,
  output logic        busy
);
  import prbs_pkg::*;

  state_t state;

  logic [DIVISOR_W-1:0]       n_sh;
  logic [15:0]                a_sh;
  logic [15:0]                o_sh;
  logic                       dirty;
  logic                       settled;
  logic                       valid_q;
  logic [DIVISOR_W-1:0]       pos;
  logic signed [SAMPLE_W-1:0] hi_r;
  logic signed [SAMPLE_W-1:0] lo_r;
  logic [DIV_W-1:0]           delta_r;
  logic [DIV_W-1:0]           step_r;

  logic signed [CALC_W-1:0]   hi_wide_c;
  logic signed [CALC_W-1:0]   lo_wide_c;
  logic signed [CALC_W-1:0]   diff_c;
  logic signed [SAMPLE_W-1:0] hi_c;
  logic signed [SAMPLE_W-1:0] lo_c;
  logic signed [SAMPLE_W-1:0] off_c;
  logic [DIV_W-1:0]           delta_c;
  logic                       cfg_change_c;
  logic                       start_c;

  logic signed [SAMPLE_W-1:0] level_c;
  logic [DIVISOR_W-1:0]       pos_next_c;
  logic                       arrive_c;
  logic signed [CALC_W-1:0]   out_w_c;
  logic signed [CALC_W-1:0]   step_w_c;
  logic signed [CALC_W-1:0]   moved_c;
  logic signed [SAMPLE_W-1:0] ramp_c;

  logic                       div_done;
  logic [DIV_W-1:0]           div_quot;

  // New high/low levels and their span, taken straight from the config inputs.
  always_comb begin
    hi_wide_c    = CALC_W'($signed(dc_offset_config)) + $signed({3'b000, amplitude_config[15:1]});
    hi_c         = sat16(hi_wide_c);
    lo_wide_c    = CALC_W'(hi_c) - $signed({2'b00, amplitude_config});
    lo_c         = sat16(lo_wide_c);
    diff_c       = CALC_W'(hi_c) - CALC_W'(lo_c);
    delta_c      = DIV_W'(diff_c);
    off_c        = sat16(CALC_W'($signed(dc_offset_config)));
    cfg_change_c = dirty || (edge_time_config != n_sh) ||
                   (amplitude_config != a_sh) || (dc_offset_config != o_sh);
    start_c      = (state == IDLE) && prbs_data_valid && cfg_change_c;
  end

  // Ramp position counts steps above the low level; the current bit sets direction,
  // so a reversal mid-ramp simply walks back over the steps already taken.
  always_comb begin
    level_c    = prbs_bit_in ? hi_r : lo_r;
    pos_next_c = prbs_bit_in ? (pos + DIVISOR_W'(1)) : (pos - DIVISOR_W'(1));
    arrive_c   = prbs_bit_in ? (pos_next_c == n_sh) : (pos_next_c == '0);
    out_w_c    = CALC_W'($signed(dac_data_out));
    step_w_c   = $signed(CALC_W'(step_r));
    moved_c    = prbs_bit_in ? (out_w_c + step_w_c) : (out_w_c - step_w_c);
    ramp_c     = arrive_c ? level_c : SAMPLE_W'(moved_c);
  end

  prbs_step_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .dac_clk  (dac_clk),
    .reset    (reset),
    .start    (start_c),
    .dividend (delta_c),
    .divisor  (edge_time_config),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge dac_clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      dac_data_out   <= '0;
      dac_data_valid <= 1'b0;
      n_sh           <= '0;
      a_sh           <= '0;
      o_sh           <= '0;
      dirty          <= 1'b1;
      settled        <= 1'b0;
      valid_q        <= 1'b0;
      pos            <= '0;
      hi_r           <= '0;
      lo_r           <= '0;
      delta_r        <= '0;
      step_r         <= '0;
    end else begin
      valid_q        <= prbs_data_valid;
      dac_data_valid <= prbs_data_valid;
      busy           <= 1'b0;
      if (!prbs_data_valid) begin
        // An interrupted calculation leaves the step unknown, so redo it later.
        if (state == CALC) dirty <= 1'b1;
        state        <= IDLE;
        dac_data_out <= off_c;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_change_c) begin
              state          <= CALC;
              busy           <= 1'b1;
              dac_data_valid <= 1'b0;
              dirty          <= 1'b0;
              n_sh           <= edge_time_config;
              a_sh           <= amplitude_config;
              o_sh           <= dc_offset_config;
              hi_r           <= hi_c;
              lo_r           <= lo_c;
              delta_r        <= delta_c;
            end else if (!valid_q || (prbs_bit_in != settled && n_sh <= DIVISOR_W'(1))) begin
              dac_data_out <= level_c;
              settled      <= prbs_bit_in;
              pos          <= prbs_bit_in ? n_sh : '0;
            end else if (prbs_bit_in != settled) begin
              state        <= RAMP;
              dac_data_out <= ramp_c;
              pos          <= pos_next_c;
            end
          end
          CALC: begin
            if (div_done) begin
              state        <= IDLE;
              step_r       <= (n_sh <= DIVISOR_W'(1)) ? delta_r : div_quot;
              dac_data_out <= level_c;
              settled      <= prbs_bit_in;
              pos          <= prbs_bit_in ? n_sh : '0;
            end else begin
              busy           <= 1'b1;
              dac_data_valid <= 1'b0;
            end
          end
          RAMP: begin
            dac_data_out <= ramp_c;
            pos          <= pos_next_c;
            if (arrive_c) begin
              state   <= IDLE;
              settled <= prbs_bit_in;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_edge_shaper.sv
// Directed bench for prbs_edge_shaper: expected samples are queued as stimulus
// is applied and compared one per clock against the DUT outputs.
module tb_prbs_edge_shaper;

  localparam int unsigned DIV_W    = 17;
  localparam int unsigned CALC_CYC = DIV_W + 1;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic        prbs_bit_in;
  logic        prbs_data_valid;
  logic [7:0]  edge_time_config;
  logic [15:0] amplitude_config;
  logic [15:0] dc_offset_config;
  logic [15:0] dac_data_out;
  logic        dac_data_valid;
  logic        busy;

  typedef struct {
    string tag;
    int    out;
    logic  valid;
    logic  bsy;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  prbs_edge_shaper #(.DIV_W(DIV_W)) dut (
    .dac_clk          (dac_clk),
    .reset            (reset),
    .prbs_bit_in      (prbs_bit_in),
    .prbs_data_valid  (prbs_data_valid),
    .edge_time_config (edge_time_config),
    .amplitude_config (amplitude_config),
    .dc_offset_config (dc_offset_config),
    .dac_data_out     (dac_data_out),
    .dac_data_valid   (dac_data_valid),
    .busy             (busy)
  );

  always #5 dac_clk = ~dac_clk;

  function automatic int sat16i(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int ref_hi(input int a, input int o);
    return sat16i(o + a / 2);
  endfunction

  function automatic int ref_lo(input int a, input int o);
    return sat16i(ref_hi(a, o) - a);
  endfunction

  task automatic push(input string tag, input int out, input logic v, input logic b);
    exp_t e;
    e.tag = tag; e.out = out; e.valid = v; e.bsy = b;
    sb.push_back(e);
  endtask

  task automatic push_calc(input string tag, input int held);
    for (int i = 0; i < int'(CALC_CYC); i++) push(tag, held, 1'b0, 1'b1);
  endtask

  // One clock: sample after the edge and check the oldest queued expectation.
  task automatic cyc();
    exp_t e;
    int   obs;
    @(posedge dac_clk);
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = int'($signed(dac_data_out));
      tests++;
      assert (obs === e.out) else begin
        fails++;
        $error("FAIL %s dac_data_out: got %0d expected %0d", e.tag, obs, e.out);
      end
      tests++;
      assert (dac_data_valid === e.valid) else begin
        fails++;
        $error("FAIL %s dac_data_valid: got %b expected %b", e.tag, dac_data_valid, e.valid);
      end
      tests++;
      assert (busy === e.bsy) else begin
        fails++;
        $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.bsy);
      end
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) cyc();
  endtask

  initial begin
    int hi, lo, step, hi2, lo2;

    reset = 1'b1; prbs_bit_in = 1'b0; prbs_data_valid = 1'b1;
    edge_time_config = 8'd4; amplitude_config = 16'h1000; dc_offset_config = 16'h0000;
    hi = ref_hi(4096, 0); lo = ref_lo(4096, 0); step = (hi - lo) / 4;

    push("reset", 0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    push_calc("boot_calc", 0);
    push("boot_snap", lo, 1'b1, 1'b0);
    drain();

    // Rising ramp, N=4: -1024, 0, 1024, forced 2048, then hold.
    prbs_bit_in = 1'b1;
    for (int k = 1; k <= 4; k++) push("ramp_up", (k == 4) ? hi : lo + k * step, 1'b1, 1'b0);
    push("ramp_up_hold", hi, 1'b1, 1'b0);
    drain();

    prbs_bit_in = 1'b0;
    for (int k = 1; k <= 4; k++) push("ramp_dn", (k == 4) ? lo : hi - k * step, 1'b1, 1'b0);
    drain();

    // Reversal after two ramp samples walks back the same two steps.
    prbs_bit_in = 1'b1;
    push("rev_fwd1", lo + step, 1'b1, 1'b0);
    push("rev_fwd2", lo + 2 * step, 1'b1, 1'b0);
    drain();
    prbs_bit_in = 1'b0;
    push("rev_back1", lo + step, 1'b1, 1'b0);
    push("rev_back2", lo, 1'b1, 1'b0);
    push("rev_hold", lo, 1'b1, 1'b0);
    drain();

    // N 4 -> 8 while settled: full CALC, then step of 512.
    edge_time_config = 8'd8;
    push_calc("n8_calc", lo);
    push("n8_snap", lo, 1'b1, 1'b0);
    drain();
    step = (hi - lo) / 8;
    prbs_bit_in = 1'b1;
    for (int k = 1; k <= 8; k++) push("n8_ramp", (k == 8) ? hi : lo + k * step, 1'b1, 1'b0);
    push("n8_hold", hi, 1'b1, 1'b0);
    drain();

    // Saturated high level with N=0: every edge is a single-cycle jump.
    amplitude_config = 16'd4000; dc_offset_config = 16'd32000; edge_time_config = 8'd0;
    hi2 = ref_hi(4000, 32000); lo2 = ref_lo(4000, 32000);
    push_calc("sat_calc", hi);
    push("sat_snap_hi", hi2, 1'b1, 1'b0);
    drain();
    prbs_bit_in = 1'b0;
    push("sat_jump_lo", lo2, 1'b1, 1'b0);
    push("sat_hold_lo", lo2, 1'b1, 1'b0);
    drain();
    prbs_bit_in = 1'b1;
    push("sat_jump_hi", hi2, 1'b1, 1'b0);
    drain();

    // Invalid PRBS data: offset level, no valid, bit changes ignored.
    prbs_data_valid = 1'b0;
    push("inval0", sat16i(32000), 1'b0, 1'b0);
    cyc();
    prbs_bit_in = 1'b0;
    push("inval1", sat16i(32000), 1'b0, 1'b0);
    cyc();
    prbs_bit_in = 1'b1;
    push("inval2", sat16i(32000), 1'b0, 1'b0);
    cyc();
    prbs_bit_in = 1'b0; prbs_data_valid = 1'b1;
    push("valid_rise", lo2, 1'b1, 1'b0);
    cyc();
    prbs_bit_in = 1'b1;
    push("post_rise_jump", hi2, 1'b1, 1'b0);
    drain();

    // Reset in the middle of a ramp abandons it and recalculates.
    amplitude_config = 16'h1000; dc_offset_config = 16'h0000; edge_time_config = 8'd4;
    step = (hi - lo) / 4;
    push_calc("pre_rst_calc", hi2);
    push("pre_rst_snap", hi, 1'b1, 1'b0);
    drain();
    prbs_bit_in = 1'b0;
    push("pre_rst_ramp", hi - step, 1'b1, 1'b0);
    cyc();
    reset = 1'b1;
    push("mid_ramp_rst", 0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    push_calc("post_rst_calc", 0);
    push("post_rst_snap", lo, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
